// File: rtl/pipe_ctrl_unit_if.sv
// Pipeline control bus between the ID/EX control stage and the rest of the core.
// Carries the ID-stage instruction fields and branch resolution in, and the
// stall/flush controls plus the registered EX-stage bundle and halt status out.
//   master : pipeline side (drives ID fields and br_taken, observes controls)
//   slave  : pipe_ctrl_unit side (consumes ID fields, produces controls)
interface pipe_ctrl_unit_if #(
  parameter int OP_W  = 4,
  parameter int FUN_W = 4,
  parameter int REG_W = 4
);
  logic             id_valid;
  logic [OP_W-1:0]  id_opcode;
  logic [FUN_W-1:0] id_funcode;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] id_rd;
  logic             br_taken;
  logic             stall;
  logic             flush;
  logic             ex_valid;
  logic [OP_W-1:0]  ex_opcode;
  logic [FUN_W-1:0] ex_funcode;
  logic [REG_W-1:0] ex_rd;
  logic [19:0]      ex_ctrl;
  logic             halted;

  modport master (
    output id_valid, id_opcode, id_funcode, id_rs1, id_rs2, id_rd, br_taken,
    input  stall, flush, ex_valid, ex_opcode, ex_funcode, ex_rd, ex_ctrl, halted
  );

  modport slave (
    input  id_valid, id_opcode, id_funcode, id_rs1, id_rs2, id_rd, br_taken,
    output stall, flush, ex_valid, ex_opcode, ex_funcode, ex_rd, ex_ctrl, halted
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Registered ID->EX control stage for a 4-stage pipeline.
// Decodes the ID opcode into the 20-bit control bundle and registers it into
// the ID/EX latch, detects load-use hazards, flushes on a taken branch from EX,
// and runs a halt state machine that drains the pipe and then freezes fetch.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : pipe_ctrl_unit_if.slave
//          in  id_valid, id_opcode, id_funcode, id_rs1, id_rs2, id_rd, br_taken
//          out stall, flush (comb); ex_valid, ex_opcode, ex_funcode, ex_rd,
//              ex_ctrl (registered); halted
// ex_ctrl layout (MSB first):
//   {seSrc[1:0], cpCtrl[1:0], memWrite[1:0], memRead[1:0], memToReg[1:0],
//    regWrite, seCtrl, aluSrc1, aluSrc4, fwSrc, pcSrc, illegal, halt, 2'b00}
module pipe_ctrl_unit #(
  parameter int OP_W         = 4,
  parameter int FUN_W        = 4,
  parameter int REG_W        = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [3:0] OP_HALT = 4'b1111;

  function automatic logic [19:0] decode(input logic [3:0] op, input logic upper_set);
    logic [19:0] c;
    c = '0;
    if (upper_set) begin
      c[3] = 1'b1;
    end else begin
      case (op)
        4'b0000: begin
          c[5] = 1'b1; c[4] = 1'b1; c[9] = 1'b1; c[11:10] = 2'd1;
        end
        4'b0001, 4'b0010: begin
          c[5] = 1'b1; c[4] = 1'b1; c[9] = 1'b1; c[11:10] = 2'd1;
          c[8] = 1'b1; c[7] = 1'b1; c[6] = 1'b1;
        end
        4'b1010: begin
          c[7] = 1'b1; c[6] = 1'b1; c[4] = 1'b1; c[9] = 1'b1; c[13:12] = 2'd2;
        end
        4'b1011: begin
          c[7] = 1'b1; c[6] = 1'b1; c[4] = 1'b1; c[15:14] = 2'd2;
        end
        4'b1100: begin
          c[7] = 1'b1; c[6] = 1'b1; c[4] = 1'b1; c[9] = 1'b1; c[13:12] = 2'd1;
        end
        4'b1101: begin
          c[7] = 1'b1; c[6] = 1'b1; c[4] = 1'b1; c[15:14] = 2'd1;
        end
        4'b0101: c[19:18] = 2'd1;
        4'b0100: begin c[19:18] = 2'd1; c[17:16] = 2'd1; end
        4'b0110: begin c[19:18] = 2'd1; c[17:16] = 2'd2; end
        4'b0111: c[19:18] = 2'd2;
        4'b1111: c[2] = 1'b1;
        default: c[3] = 1'b1;
      endcase
    end
    return c;
  endfunction

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic             ex_valid_p1;
  logic [OP_W-1:0]  ex_opcode_p1;
  logic [FUN_W-1:0] ex_funcode_p1;
  logic [REG_W-1:0] ex_rd_p1;
  logic [19:0]      ex_ctrl_p1;

  logic        upper_set;
  logic [19:0] id_ctrl;
  logic        load_use;
  logic        stall_int;
  logic        bubble;
  logic        halt_accept;

  // ---- ID stage: decode and hazard detection ----
  // Upper opcode bits beyond the decoded nibble make the instruction illegal.
  assign upper_set = (bus.id_opcode >> 4) != '0;
  assign id_ctrl   = decode(bus.id_opcode[3:0], upper_set);

  assign load_use = bus.id_valid && ex_valid_p1 && (ex_ctrl_p1[13:12] != 2'd0) &&
                    (ex_rd_p1 != '0) &&
                    ((ex_rd_p1 == bus.id_rs1) || (ex_rd_p1 == bus.id_rs2));

  // A taken branch overrides every stall source: IF/ID is being killed anyway.
  assign stall_int = !bus.br_taken && (load_use || (state != ST_RUN));
  assign bubble    = stall_int || bus.br_taken || !bus.id_valid || (state != ST_RUN);

  assign halt_accept = (state == ST_RUN) && bus.id_valid && !upper_set &&
                       (bus.id_opcode[3:0] == OP_HALT) && !bus.br_taken && !stall_int;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RUN: begin
        if (halt_accept) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = CNT_W'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = ST_HALTED;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---- ID/EX latch ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_p1   <= 1'b0;
      ex_opcode_p1  <= '0;
      ex_funcode_p1 <= '0;
      ex_rd_p1      <= '0;
      ex_ctrl_p1    <= '0;
    end else if (bubble) begin
      ex_valid_p1   <= 1'b0;
      ex_opcode_p1  <= '0;
      ex_funcode_p1 <= '0;
      ex_rd_p1      <= '0;
      ex_ctrl_p1    <= '0;
    end else begin
      ex_valid_p1   <= 1'b1;
      ex_opcode_p1  <= bus.id_opcode;
      ex_funcode_p1 <= bus.id_funcode;
      ex_rd_p1      <= bus.id_rd;
      ex_ctrl_p1    <= id_ctrl;
    end
  end

  assign bus.stall      = stall_int;
  assign bus.flush      = bus.br_taken;
  assign bus.ex_valid   = ex_valid_p1;
  assign bus.ex_opcode  = ex_opcode_p1;
  assign bus.ex_funcode = ex_funcode_p1;
  assign bus.ex_rd      = ex_rd_p1;
  assign bus.ex_ctrl    = ex_ctrl_p1;
  assign bus.halted     = (state == ST_HALTED);

endmodule
